// File: rtl/img_ctrl_pkg.sv
// Shared types, default parameters and elaboration helpers for the image
// read/process/write sequencer.
package img_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_NUM_PIX    = 65536;
  localparam int DEF_NUM_PHASES = 8;
  localparam int DEF_SEL_W      = 3;
  localparam int DEF_RD_LAT     = 2;

  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Latency-matching shift register of {valid, address}; DEPTH cycles in to out,
// no backpressure. Invalid slots carry a zero address so outputs idle at 0.
module rd_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_addr,
  output logic         out_vld,
  output logic [W-1:0] out_addr
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     addr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_vld ? in_addr : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/img_ctrl_seq.sv
// Frame sequencer: walks NUM_PIX pixels x NUM_PHASES phases on start, issues
// BRAM read controls and RD_LAT-delayed write-back; all outputs registered.
module img_ctrl_seq
  import img_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_PIX    = DEF_NUM_PIX,
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  output logic [SEL_W-1:0]  sel,
  output logic              enb,
  output logic              wea,
  output logic [ADDR_W-1:0] addrb,
  output logic              busy,
  output logic              complete
);

  if (NUM_PIX < 1 || longint'(NUM_PIX) > (longint'(1) << ADDR_W)) begin : g_bad_pix
    $error("img_ctrl_seq: NUM_PIX out of range for ADDR_W");
  end
  if (NUM_PHASES < 2 || clog2(NUM_PHASES) > SEL_W) begin : g_bad_phases
    $error("img_ctrl_seq: NUM_PHASES must be >= 2 and fit in SEL_W");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("img_ctrl_seq: RD_LAT must be >= 1");
  end

  localparam int CNT_W = (RD_LAT > 1) ? clog2(RD_LAT) : 1;
  // Explicit last-value compares so NUM_PIX = 2^ADDR_W never needs a carry.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(RD_LAT - 1);

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] addra_q, addra_nx;
  logic [SEL_W-1:0]  sel_q, sel_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              ena_q, busy_q, complete_q;
  logic              tok_vld;
  logic              abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addra_q    <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_nx;
      addra_q    <= addra_nx;
      sel_q      <= sel_nx;
      cnt_q      <= cnt_nx;
      ena_q      <= (state_nx == RUN);
      busy_q     <= (state_nx != IDLE);
      complete_q <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx  = state_q;
    addra_nx  = addra_q;
    sel_nx    = sel_q;
    cnt_nx    = cnt_q;
    tok_vld   = 1'b0;
    abort_hit = abort && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        addra_nx = '0;
        sel_nx   = '0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (sel_q == LAST_SEL) begin
          tok_vld = 1'b1;
          if (addra_q == LAST_ADDR) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end else begin
            sel_nx   = '0;
            addra_nx = addra_q + ADDR_W'(1);
          end
        end else begin
          sel_nx = sel_q + SEL_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_CNT) begin
          state_nx = DONE;
          addra_nx = '0;
          sel_nx   = '0;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        addra_nx = '0;
        sel_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over everything, including a token entering this cycle.
    if (abort_hit) begin
      state_nx = IDLE;
      addra_nx = '0;
      sel_nx   = '0;
      tok_vld  = 1'b0;
    end
  end

  logic pipe_vld;

  rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .W     (ADDR_W)
  ) u_wr_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort_hit),
    .in_vld   (tok_vld),
    .in_addr  (addra_q),
    .out_vld  (pipe_vld),
    .out_addr (addrb)
  );

  assign ena      = ena_q;
  assign addra    = addra_q;
  assign sel      = sel_q;
  assign wea      = pipe_vld;
  assign enb      = pipe_vld;
  assign busy     = busy_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_img_ctrl_seq.sv
// Scoreboard bench: three sequencer configurations, expected write/complete
// events queued at stimulus time and popped as the DUTs produce them.
module tb_img_ctrl_seq;

  localparam int A_PIX = 4, A_PH = 8, A_RL = 2;
  localparam int A_RUN = A_PIX * A_PH;

  typedef struct {
    int cyc;
    int addr;
    bit cmp;
  } ev_t;

  ev_t evq [3][$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: NUM_PIX=4, NUM_PHASES=8, RD_LAT=2
  logic        a_start, a_abort, a_ena, a_enb, a_wea, a_busy, a_complete;
  logic [15:0] a_addra, a_addrb;
  logic [2:0]  a_sel;
  img_ctrl_seq #(.ADDR_W(16), .NUM_PIX(A_PIX), .NUM_PHASES(A_PH), .SEL_W(3), .RD_LAT(A_RL)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .ena(a_ena), .addra(a_addra),
    .sel(a_sel), .enb(a_enb), .wea(a_wea), .addrb(a_addrb), .busy(a_busy), .complete(a_complete));

  // DUT B: NUM_PIX=1, NUM_PHASES=2, RD_LAT=1
  logic        b_start, b_abort, b_ena, b_enb, b_wea, b_busy, b_complete;
  logic [15:0] b_addra, b_addrb;
  logic [0:0]  b_sel;
  img_ctrl_seq #(.ADDR_W(16), .NUM_PIX(1), .NUM_PHASES(2), .SEL_W(1), .RD_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .ena(b_ena), .addra(b_addra),
    .sel(b_sel), .enb(b_enb), .wea(b_wea), .addrb(b_addrb), .busy(b_busy), .complete(b_complete));

  // DUT C: full address space, ADDR_W=4, NUM_PIX=16
  logic        c_start, c_abort, c_ena, c_enb, c_wea, c_busy, c_complete;
  logic [3:0]  c_addra, c_addrb;
  logic [0:0]  c_sel;
  img_ctrl_seq #(.ADDR_W(4), .NUM_PIX(16), .NUM_PHASES(2), .SEL_W(1), .RD_LAT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .ena(c_ena), .addra(c_addra),
    .sel(c_sel), .enb(c_enb), .wea(c_wea), .addrb(c_addrb), .busy(c_busy), .complete(c_complete));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic push_frame(input int d, input int t0, input int npx, input int np,
                            input int rl, input int nwr, input bit cmpl);
    ev_t ev;
    for (int k = 0; k < nwr; k++) begin
      ev.cyc = t0 + (k + 1) * np + rl;
      ev.addr = k;
      ev.cmp = 1'b0;
      evq[d].push_back(ev);
    end
    if (cmpl) begin
      ev.cyc = t0 + npx * np + rl + 1;
      ev.addr = 0;
      ev.cmp = 1'b1;
      evq[d].push_back(ev);
    end
  endtask

  task automatic check_ev(input int d, input logic w, input logic e, input int ab, input logic c);
    ev_t ev;
    if (w || e || c) begin
      if (evq[d].size() == 0) begin
        chk($sformatf("d%0d_unexpected_out", d), int'(w | e | c), 0);
      end else begin
        ev = evq[d].pop_front();
        chk($sformatf("d%0d_event_cycle", d), cyc, ev.cyc);
        chk($sformatf("d%0d_complete", d), int'(c), int'(ev.cmp));
        chk($sformatf("d%0d_wea", d), int'(w), int'(!ev.cmp));
        chk($sformatf("d%0d_enb", d), int'(e), int'(!ev.cmp));
        if (!ev.cmp) chk($sformatf("d%0d_addrb", d), ab, ev.addr);
      end
    end else begin
      chk($sformatf("d%0d_addrb_idle", d), ab, 0);
    end
  endtask

  // Reference timing for DUT A, relative to the cycle start was driven
  int a_t0 = 0;
  int a_end = 0;
  bit a_act = 1'b0;

  always @(posedge clk) begin
    int  rel;
    bit  eb, ee;
    #1;
    check_ev(0, a_wea, a_enb, int'(a_addrb), a_complete);
    rel = cyc - a_t0;
    eb = a_act && rel >= 1 && rel <= a_end;
    ee = eb && rel <= A_RUN;
    chk("a_busy", int'(a_busy), int'(eb));
    chk("a_ena", int'(a_ena), int'(ee));
    if (ee) begin
      chk("a_sel_run", a_sel, (rel - 1) % A_PH);
      chk("a_addra_run", a_addra, (rel - 1) / A_PH);
    end else if (eb && rel <= A_RUN + A_RL) begin
      chk("a_sel_drain", a_sel, A_PH - 1);
      chk("a_addra_drain", a_addra, A_PIX - 1);
    end else if (!eb) begin
      chk("a_sel_idle", a_sel, 0);
      chk("a_addra_idle", a_addra, 0);
    end
  end

  int c_max = 0;
  always @(posedge clk) begin
    #1;
    check_ev(1, b_wea, b_enb, int'(b_addrb), b_complete);
    check_ev(2, c_wea, c_enb, int'(c_addrb), c_complete);
    if (int'(c_addra) > c_max) c_max = int'(c_addra);
  end

  initial begin
    rst_n = 1'b0;
    {a_start, a_abort, b_start, b_abort, c_start, c_abort} = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain frame on A, concurrent single-pixel frame on B and full-space frame on C
    a_t0 = cyc; a_end = A_RUN + A_RL + 1; a_act = 1'b1;
    push_frame(0, cyc, A_PIX, A_PH, A_RL, A_PIX, 1'b1);
    push_frame(1, cyc, 1, 2, 1, 1, 1'b1);
    push_frame(2, cyc, 16, 2, 3, 16, 1'b1);
    a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    repeat (45) @(negedge clk);
    chk("c_addra_max", c_max, 15);

    // start held high: one frame, next accepted only in the cycle after complete
    a_t0 = cyc;
    push_frame(0, cyc, A_PIX, A_PH, A_RL, A_PIX, 1'b1);
    a_start = 1'b1;
    repeat (36) @(negedge clk);
    a_t0 = cyc;
    push_frame(0, cyc, A_PIX, A_PH, A_RL, A_PIX, 1'b1);
    @(negedge clk);
    a_start = 1'b0;
    repeat (45) @(negedge clk);

    // Abort at relative cycle 20
    a_t0 = cyc; a_end = 20;
    push_frame(0, cyc, A_PIX, A_PH, A_RL, 2, 1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (19) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    repeat (30) @(negedge clk);

    // Asynchronous reset at relative cycle 15
    a_t0 = cyc; a_end = A_RUN + A_RL + 1;
    push_frame(0, cyc, A_PIX, A_PH, A_RL, 1, 1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (14) @(negedge clk);
    a_act = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ena", int'(a_ena), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_addra", a_addra, 0);
    chk("rst_wea", int'(a_wea), 0);
    chk("rst_complete", int'(a_complete), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Recovery frame after reset
    a_t0 = cyc; a_end = A_RUN + A_RL + 1; a_act = 1'b1;
    push_frame(0, cyc, A_PIX, A_PH, A_RL, A_PIX, 1'b1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (45) @(negedge clk);

    for (int d = 0; d < 3; d++) chk($sformatf("d%0d_pending_events", d), evq[d].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/img_ctrl_seq.md
# img_ctrl_seq

Parametrised BRAM read/process/write sequencer for the image-processing datapath. On a `start` pulse it walks a frame of `NUM_PIX` pixels, holding each pixel address for `NUM_PHASES` cycles while a phase select steps through the processing stages. It issues the read-port address/enable for the source BRAM and a latency-aligned write enable/address for the result BRAM, then pulses `complete` once the last write has drained. It replaces free-running select/enable generation with a start/busy/complete handshake and an abort path.

## Interface
- `ADDR_W`, 16: width of `addra`/`addrb`.
- `NUM_PIX`, 65536: pixels per frame; 1 ≤ NUM_PIX ≤ 2^ADDR_W.
- `NUM_PHASES`, 8: select phases per pixel; ≥ 2.
- `SEL_W`, 3: width of `sel`; 2^SEL_W ≥ NUM_PHASES.
- `RD_LAT`, 2: cycles from last-phase read to write-back; ≥ 1.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin frame; sampled only in IDLE.
- `abort`  in  1  synchronous cancel, any state.
- `ena`  out  1  source BRAM port-A enable.
- `addra`  out  ADDR_W  source read address.
- `sel`  out  SEL_W  processing phase select.
- `enb`  out  1  result BRAM port-B enable; equals `wea`.
- `wea`  out  1  result write enable.
- `addrb`  out  ADDR_W  result write address.
- `busy`  out  1  state ≠ IDLE.
- `complete`  out  1  one-cycle end-of-frame pulse.

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: all outputs 0. `start`=1 → RUN next cycle with addra=0, sel=0.
- RUN: `ena`=1.
  - `sel` increments by 1 each cycle and wraps NUM_PHASES-1 → 0.
  - On the wrap, `addra` increments by 1.
  - In a cycle with sel=NUM_PHASES-1, a write token carrying the current addra enters an RD_LAT-deep delay line.
  - When addra=NUM_PIX-1 and sel=NUM_PHASES-1: go to DRAIN. addra and sel do not advance past this point.
- DRAIN: `ena`=0 and `sel` holds. Lasts exactly RD_LAT cycles, then DONE.
- DONE: `complete`=1 for one cycle, then IDLE. `addra`/`sel` return to 0.
- Write side: `wea`=`enb`=1 and `addrb`=token address when a token exits the delay line. `addrb`=0 when no token.
- `abort`=1 in any non-IDLE state:
  - next cycle IDLE, delay line flushed, no further `wea`;
  - `complete` not asserted.
  - `abort` takes priority over `start`.
- `start` outside IDLE is ignored. `start` in the DONE cycle is ignored.
- Reset (async, any time, including mid-frame): state IDLE, delay line cleared, every output 0. Outputs stay 0 until a new `start` after release.
- Arithmetic: counters are unsigned and wrap-free by construction. NUM_PIX=2^ADDR_W must not overflow the end compare; use an explicit last-address compare, not a carry.

## Timing
- All outputs are registered.
- `start` in cycle 0 → first RUN cycle is 1.
- RUN length is NUM_PIX·NUM_PHASES cycles. Pixel k's last phase is at cycle (k+1)·NUM_PHASES.
- `wea` for pixel k occurs at cycle (k+1)·NUM_PHASES + RD_LAT, with addrb=k.
- `complete` occurs at cycle NUM_PIX·NUM_PHASES + RD_LAT + 1.
- `busy` is high from cycle 1 through the `complete` cycle inclusive.
- Back-to-back frames: earliest new `start` is the cycle after `complete`.

## Structure
- Package `img_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default parameter constants;
  - a clog2 helper for SEL_W/ADDR_W checks.
- Sub-module `rd_lat_pipe`: RD_LAT-stage shift register of {valid, ADDR_W address} with async reset and synchronous flush. It is reused for other latency-matched write-backs.
- Elaboration-time checks on parameter legality.

## Test plan
- NUM_PIX=4, NUM_PHASES=8, RD_LAT=2, `start` at cycle 0:
  - sel runs 0..7 four times over cycles 1–32;
  - wea at cycles 10/18/26/34 with addrb 0/1/2/3;
  - complete at cycle 35 only; busy high cycles 1–35.
- `start` held high through the whole frame → exactly one frame. Second frame begins only at cycle 36.
- `abort` at cycle 20 of the above frame → IDLE at 21. wea seen only at 10 and 18; complete never asserted.
- rst_n low at cycle 15 (async, mid-RUN) → all outputs 0 immediately. After release, no wea until a new `start`.
- NUM_PIX=1, NUM_PHASES=2, RD_LAT=1 → wea at cycle 3 with addrb=0; complete at cycle 4.
- ADDR_W=4, NUM_PIX=16 → addra reaches 15 without wrap; last wea has addrb=15; complete follows.
